// File: rtl/fpu_norm_round.sv
// Normalize/round back end for the FMA/add datapath: raw 49-bit significand sum in,
// packed binary32 result plus fflags out, one operation every four cycles.
// state | meaning
// IDLE  | waiting for an operand set, in_ready_o high
// NORM  | leading 1 moved to bit 46, or denormalized to the exp=1 scale
// ROUND | rounding and packing, result registered on exit
// DONE  | result held on out_*_o until out_ready_i
module fpu_norm_round #(
    parameter int EXP_W = 10,
    parameter int SUM_W = 49
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SUM_W-1:0]        in_sum_i,
    input  logic                    in_sign_i,
    input  logic signed [EXP_W-1:0] in_exp_i,
    input  logic                    in_sticky_i,
    input  logic [2:0]              in_rm_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             out_result_o,
    output logic [4:0]              out_fflags_o
);

    localparam int XW = EXP_W + 3;
    localparam int NW = SUM_W - 2;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SUM_W-1:0]        sum_q;
    logic                    sign_q, sticky_q;
    logic signed [EXP_W-1:0] exp_q;
    logic [2:0]              rm_q;
    logic [NW-1:0]           n_q;
    logic signed [XW-1:0]    e_q;
    logic                    nst_q;
    logic [31:0]             result_q;
    logic [4:0]              fflags_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid_i) state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    function automatic logic [5:0] lzc(input logic [NW-1:0] v);
        logic [5:0] cnt;
        logic       found;
        cnt   = 6'(NW);
        found = 1'b0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                cnt   = 6'(NW - 1 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    logic [5:0]           lz, sh_l, sh_r;
    logic signed [XW-1:0] exp_x, lz_x, e1, neg, e_norm_d;
    logic [NW-1:0]        n_d;
    logic                 st_d;
    logic [SUM_W-1:0]     mask_r;

    assign lz = lzc(sum_q[NW-1:0]);

    always_comb begin
        exp_x    = XW'(exp_q);
        lz_x     = XW'(lz);
        n_d      = '0;
        st_d     = sticky_q;
        e_norm_d = '0;
        sh_l     = '0;
        sh_r     = '0;
        neg      = '0;
        mask_r   = '0;
        if (sum_q[SUM_W-1])      e1 = exp_x + XW'(2);
        else if (sum_q[SUM_W-2]) e1 = exp_x + XW'(1);
        else                     e1 = exp_x - lz_x;

        if (!e1[XW-1] && (e1 != '0)) begin
            e_norm_d = e1;
            if (sum_q[SUM_W-1]) begin
                n_d  = NW'(sum_q >> 2);
                st_d = sticky_q | (|sum_q[1:0]);
            end else if (sum_q[SUM_W-2]) begin
                n_d  = NW'(sum_q >> 1);
                st_d = sticky_q | sum_q[0];
            end else begin
                n_d = NW'(sum_q << lz);
            end
        end else if (!exp_x[XW-1] && (exp_x != '0)) begin
            // Left shift stops at the exp=1 scale; the leading 1 stays below bit 46.
            sh_l = 6'(exp_x - XW'(1));
            n_d  = NW'(sum_q << sh_l);
        end else begin
            // A shift of 28 already pushes even bit 48 entirely into sticky.
            neg    = XW'(1) - exp_x;
            sh_r   = (neg > XW'(28)) ? 6'd28 : 6'(neg);
            mask_r = (SUM_W'(1) << sh_r) - SUM_W'(1);
            n_d    = NW'(sum_q >> sh_r);
            st_d   = sticky_q | (|(sum_q & mask_r));
        end
    end

    logic [22:0]          mant, mant_r;
    logic                 g, r, s, inc, cout, nx, of, uf, to_inf, zero;
    logic signed [XW-1:0] e_fin;
    logic [31:0]          res_d;
    logic [4:0]           flg_d;

    always_comb begin
        mant = n_q[NW-2:NW-24];
        g    = n_q[NW-25];
        r    = n_q[NW-26];
        s    = (|n_q[NW-27:0]) | nst_q;
        nx   = g | r | s;
        unique case (rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_q & nx;
            RM_RUP:  inc = ~sign_q & nx;
            RM_RMM:  inc = g;
            default: inc = g & (r | s | mant[0]);
        endcase
        {cout, mant_r} = {1'b0, mant} + 24'(inc);
        e_fin  = e_q + $signed({{(XW-1){1'b0}}, cout});
        of     = (e_fin >= XW'(255));
        uf     = nx && (e_fin == '0) && !of;
        zero   = (sum_q == '0) && !sticky_q;
        unique case (rm_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign_q;
            RM_RUP:  to_inf = ~sign_q;
            default: to_inf = 1'b1;
        endcase
        res_d = {sign_q, e_fin[7:0], mant_r};
        flg_d = {3'b000, uf, nx};
        if (zero) begin
            res_d = {sign_q, 31'b0};
            flg_d = 5'b00000;
        end else if (of) begin
            res_d = to_inf ? {sign_q, 8'hFF, 23'h000000} : {sign_q, 8'hFE, 23'h7FFFFF};
            flg_d = 5'b00101;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            rm_q     <= '0;
            n_q      <= '0;
            e_q      <= '0;
            nst_q    <= 1'b0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid_i && !flush_i) begin
                sum_q    <= in_sum_i;
                sign_q   <= in_sign_i;
                exp_q    <= in_exp_i;
                sticky_q <= in_sticky_i;
                rm_q     <= in_rm_i;
            end
            if (state_q == S_NORM) begin
                n_q   <= n_d;
                e_q   <= e_norm_d;
                nst_q <= st_d;
            end
            if (state_q == S_ROUND && !flush_i) begin
                result_q <= res_d;
                fflags_q <= flg_d;
            end
        end
    end

    assign in_ready_o   = (state_q == S_IDLE);
    assign out_valid_o  = (state_q == S_DONE);
    assign out_result_o = result_q;
    assign out_fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed bench for fpu_norm_round: hand-computed binary32 results, latency,
// backpressure, async reset mid-operation and flush.
module tb_fpu_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, in_valid, in_ready, in_sign, in_sticky, out_valid, out_ready;
    logic [48:0] in_sum;
    logic signed [9:0] in_exp;
    logic [2:0]  in_rm;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;

    int checks = 0;
    int errors = 0;

    localparam logic [48:0] ONE46 = 49'd1 << 46;
    localparam logic [48:0] ONE48 = 49'd1 << 48;
    localparam logic [48:0] ALL47 = (49'd1 << 47) - 49'd1;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    fpu_norm_round dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_sum_i     (in_sum),
        .in_sign_i    (in_sign),
        .in_exp_i     (in_exp),
        .in_sticky_i  (in_sticky),
        .in_rm_i      (in_rm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_result_o (out_result),
        .out_fflags_o (out_fflags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic [48:0] sum, input logic sign,
                            input logic signed [9:0] e, input logic st, input logic [2:0] rm);
        check({tag, "_in_ready"}, in_ready, 1);
        in_sum    = sum;
        in_sign   = sign;
        in_exp    = e;
        in_sticky = st;
        in_rm     = rm;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
    endtask

    task automatic run_op(input string tag, input logic [48:0] sum, input logic sign,
                          input logic signed [9:0] e, input logic st, input logic [2:0] rm,
                          input logic [31:0] er, input logic [4:0] ef);
        start_op(tag, sum, sign, e, st, rm);
        wait_valid(tag);
        check({tag, "_result"}, out_result, er);
        check({tag, "_fflags"}, {27'b0, out_fflags}, {27'b0, ef});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        flush = 0; in_valid = 0; out_ready = 0; in_sum = '0; in_sign = 0;
        in_exp = '0; in_sticky = 0; in_rm = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_fflags", {27'b0, out_fflags}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run_op("one",        ONE46, 0, 127, 0, RNE, 32'h3F800000, 5'b00000);
        run_op("four",       ONE48, 0, 127, 0, RNE, 32'h40800000, 5'b00000);
        run_op("four_rup",   ONE48 | 49'd1, 0, 127, 0, RUP, 32'h40800001, 5'b00001);
        run_op("tie_even",   (49'd1 << 47) | (49'd1 << 23), 0, 127, 0, RNE, 32'h40000000, 5'b00001);
        run_op("lshift26",   49'd1 << 20, 0, 127, 0, RNE, 32'h32800000, 5'b00000);
        run_op("of_rne",     ALL47, 0, 254, 0, RNE, 32'h7F800000, 5'b00101);
        run_op("near_rtz",   ALL47, 0, 254, 0, RTZ, 32'h7F7FFFFF, 5'b00001);
        run_op("of_rtz",     ONE46, 0, 255, 0, RTZ, 32'h7F7FFFFF, 5'b00101);
        run_op("of_rdn_neg", ONE46, 1, 255, 0, RDN, 32'hFF800000, 5'b00101);
        run_op("of_rup_neg", ONE46, 1, 255, 0, RUP, 32'hFF7FFFFF, 5'b00101);
        run_op("of_rdn_pos", ONE46, 0, 255, 0, RDN, 32'h7F7FFFFF, 5'b00101);
        run_op("sub_exact",  ONE46, 0, -10, 0, RNE, 32'h00001000, 5'b00000);
        run_op("sub_zero",   ONE46, 0, -23, 0, RNE, 32'h00000000, 5'b00011);
        run_op("sub_rup",    ONE46, 0, -24, 1, RUP, 32'h00000001, 5'b00011);
        run_op("sub_carry",  ALL47, 0, 0, 0, RNE, 32'h00800000, 5'b00001);
        run_op("sub_lshift", 49'd1 << 40, 0, 3, 0, RNE, 32'h00080000, 5'b00000);
        run_op("rmm_tie",    ONE46 | (49'd1 << 22), 0, 127, 0, RMM, 32'h3F800001, 5'b00001);
        run_op("rm5_as_rne", ONE46 | (49'd3 << 22), 0, 127, 0, 3'd5, 32'h3F800002, 5'b00001);
        run_op("rdn_neg",    ONE46 | 49'd1, 1, 127, 0, RDN, 32'hBF800001, 5'b00001);
        run_op("rup_neg",    ONE46 | 49'd1, 1, 127, 0, RUP, 32'hBF800000, 5'b00001);
        run_op("neg_zero",   49'd0, 1, 127, 0, RNE, 32'h80000000, 5'b00000);

        start_op("bp", ONE46, 0, 127, 0, RNE);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", out_result, 32'h3F800000);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);

        start_op("rst_mid", ONE48, 0, 127, 0, RNE);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_result", out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_valid", out_valid, 0);
        end

        run_op("pre_flush", ONE48, 0, 127, 0, RNE, 32'h40800000, 5'b00000);
        start_op("flush", ONE46, 1, 127, 0, RNE);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        repeat (4) begin
            check("flush_no_valid", out_valid, 0);
            @(negedge clk);
        end
        check("flush_result_kept", out_result, 32'h40800000);

        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_blocks_accept", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
